halve_tokens: RTL and testbench

- Serial token decoder: the receiving end of the token-doubling link.
- Consumes a stream in which every original '1' token arrives doubled, and recovers one token per pair of '1's.
- Reports each decoded run length, a running decoded-token total, a sticky odd-run protocol error and a sticky overflow error.
- Sits directly after the serial link, ahead of token consumers.

---
 rtl/halve_tokens_if.sv | 27 ++
 rtl/halve_tokens.sv | 73 +++++++
 tb/tb_halve_tokens.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/halve_tokens_if.sv
// Port bundle for the doubled-token decoder: the incoming serial stream plus the
// decoded pulse, per-run length, running total and sticky error flags.
interface halve_tokens_if #(
  parameter int MAX_RUN = 400,
  parameter int TOT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_RUN / 2 + 1);

  logic             a;
  logic             b;
  logic [LEN_W-1:0] run_len;
  logic             run_valid;
  logic [TOT_W-1:0] tok_total;
  logic             odd_err;
  logic             overflow;

  // The link drives a; the decoder answers with everything else.
  modport master (
    output a,
    input  b, run_len, run_valid, tok_total, odd_err, overflow
  );

  modport slave (
    input  a,
    output b, run_len, run_valid, tok_total, odd_err, overflow
  );
endinterface

// File: rtl/halve_tokens.sv
// Decodes a stream where every original '1' token arrives doubled: emits one pulse
// per pair of '1's, reports run lengths, a saturating total and sticky errors.
module halve_tokens #(
  parameter int MAX_RUN = 400,
  parameter int TOT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  halve_tokens_if.slave tk
);
  localparam int CNT_W = $clog2(MAX_RUN + 1);
  localparam int LEN_W = $clog2(MAX_RUN / 2 + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_prev_a;
  logic             r_b;
  logic             r_run_valid;
  logic [LEN_W-1:0] r_run_len;
  logic [TOT_W-1:0] r_tok_total;
  logic             r_odd_err;
  logic             r_overflow;

  logic w_cnt_max;
  logic w_run_end;
  logic w_tot_sat;

  assign w_cnt_max = (r_cnt == CNT_W'(MAX_RUN));
  assign w_run_end = r_prev_a & ~tk.a;
  assign w_tot_sat = &r_tok_total;

  // Once overflow is set the whole decoder freezes until reset; b and run_valid
  // were already cleared on the cycle that raised it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_prev_a    <= 1'b0;
      r_b         <= 1'b0;
      r_run_valid <= 1'b0;
      r_run_len   <= '0;
      r_tok_total <= '0;
      r_odd_err   <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (!r_overflow) begin
      r_prev_a    <= tk.a;
      r_b         <= 1'b0;
      r_run_valid <= 1'b0;
      if (tk.a) begin
        if (w_cnt_max) begin
          r_overflow <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          // An odd count before this sample means this '1' completes a pair.
          if (r_cnt[0]) begin
            r_b <= 1'b1;
            if (!w_tot_sat) r_tok_total <= r_tok_total + TOT_W'(1);
          end
        end
      end else if (w_run_end) begin
        r_run_valid <= 1'b1;
        r_run_len   <= LEN_W'(r_cnt >> 1);
        r_odd_err   <= r_odd_err | r_cnt[0];
        r_cnt       <= '0;
      end
    end
  end

  assign tk.b         = r_b;
  assign tk.run_len   = r_run_len;
  assign tk.run_valid = r_run_valid;
  assign tk.tok_total = r_tok_total;
  assign tk.odd_err   = r_odd_err;
  assign tk.overflow  = r_overflow;
endmodule

// File: tb/tb_halve_tokens.sv
// Bench for halve_tokens: two instances (16-bit and 4-bit totals) share one stream;
// expectations come from a run-level model built from each run's length.
module tb_halve_tokens;
  localparam int MAX_RUN = 400;
  localparam int LEN_W   = $clog2(MAX_RUN / 2 + 1);
  localparam int MW      = 512;

  logic clk = 1'b0;
  logic rst;
  logic a;

  always #5 clk = ~clk;

  halve_tokens_if #(.MAX_RUN(MAX_RUN), .TOT_W(16)) bus ();
  halve_tokens_if #(.MAX_RUN(MAX_RUN), .TOT_W(4))  bus4 ();
  assign bus.a  = a;
  assign bus4.a = a;

  halve_tokens #(.MAX_RUN(MAX_RUN), .TOT_W(16)) dut  (.clk(clk), .rst(rst), .tk(bus));
  halve_tokens #(.MAX_RUN(MAX_RUN), .TOT_W(4))  dut4 (.clk(clk), .rst(rst), .tk(bus4));

  int n_vec = 0;
  int n_err = 0;

  // Observations over one driven run, indexed by cycles after the run's first '1'.
  logic [MW-1:0] obs_b, obs_rv, obs_b4, obs_rv4, obs_ovf;
  logic [LEN_W-1:0] got_q[$];

  // Reference model state, at the granularity of whole runs.
  int ref_total, ref_total4, ref_len;
  bit ref_odd, ref_ovf;
  logic [MW-1:0] exp_b, exp_rv, exp_ovf;
  logic [LEN_W-1:0] exp_q[$];
  logic [LEN_W-1:0] g_len, e_len;

  task automatic ref_reset();
    ref_total = 0; ref_total4 = 0; ref_len = 0; ref_odd = 0; ref_ovf = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic ref_apply(input int len, input int gap);
    int pairs;
    exp_b = '0; exp_rv = '0; exp_ovf = '0;
    pairs = 0;
    if (ref_ovf) begin
      for (int i = 1; i <= len + gap; i++) exp_ovf[i] = 1'b1;
    end else if (len > MAX_RUN) begin
      pairs = MAX_RUN / 2;
      for (int i = MAX_RUN + 1; i <= len + gap; i++) exp_ovf[i] = 1'b1;
      ref_ovf = 1;
    end else begin
      pairs   = len / 2;
      ref_len = pairs;
      if (len % 2 != 0) ref_odd = 1;
      exp_rv[len + 1] = 1'b1;
      exp_q.push_back(LEN_W'(pairs));
    end
    for (int k = 1; k <= pairs; k++) exp_b[2 * k] = 1'b1;
    ref_total  = (ref_total + pairs > 65535) ? 65535 : ref_total + pairs;
    ref_total4 = (ref_total4 + pairs > 15) ? 15 : ref_total4 + pairs;
  endtask

  task automatic drive_run(input int len, input int gap);
    obs_b = '0; obs_rv = '0; obs_b4 = '0; obs_rv4 = '0; obs_ovf = '0;
    for (int i = 1; i <= len + gap; i++) begin
      a = (i <= len);
      @(posedge clk); #1;
      obs_b[i]   = bus.b;
      obs_rv[i]  = bus.run_valid;
      obs_b4[i]  = bus4.b;
      obs_rv4[i] = bus4.run_valid;
      obs_ovf[i] = bus.overflow;
      if (bus.run_valid) got_q.push_back(bus.run_len);
    end
  endtask

  task automatic do_reset(input logic a_val);
    rst = 1'b1; a = a_val;
    @(posedge clk); #1;
    rst = 1'b0; a = 1'b0;
    ref_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 1'(i % 2);
      @(posedge clk); #1;
    end
    n_vec++;
    if ({bus.b, bus.run_valid, bus.run_len, bus.tok_total, bus.odd_err, bus.overflow} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got b=%b rv=%b len=%0d tot=%0d odd=%b ovf=%b want all 0",
        bus.b, bus.run_valid, bus.run_len, bus.tok_total, bus.odd_err, bus.overflow);
    end
    n_vec++;
    if ({bus4.b, bus4.run_valid, bus4.tok_total} !== '0) begin
      n_err++; $display("FAIL reset_outputs_t4: got b=%b rv=%b tot=%0d want 0", bus4.b, bus4.run_valid, bus4.tok_total);
    end
    rst = 1'b0; a = 1'b0;
    ref_reset();
  endtask

  task automatic test_pair_decode();
    do_reset(1'b1);
    drive_run(4, 1); ref_apply(4, 1);
    n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL pair_b: got %h want %h", obs_b, exp_b); end
    n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL pair_rv: got %h want %h", obs_rv, exp_rv); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL pair_rv_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g_len = got_q.pop_front(); e_len = exp_q.pop_front();
      n_vec++; if (g_len !== e_len) begin n_err++; $display("FAIL pair_len: got %0d want %0d", g_len, e_len); end
    end
    n_vec++; if (bus.tok_total !== 16'(ref_total)) begin n_err++; $display("FAIL pair_total: got %0d want %0d", bus.tok_total, ref_total); end
    n_vec++; if (bus.odd_err !== ref_odd) begin n_err++; $display("FAIL pair_odd: got %b want %b", bus.odd_err, ref_odd); end
  endtask

  task automatic test_odd_run();
    int lens[2] = '{3, 2};
    do_reset(1'b0);
    foreach (lens[r]) begin
      drive_run(lens[r], 1); ref_apply(lens[r], 1);
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL odd_b[%0d]: got %h want %h", r, obs_b, exp_b); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL odd_rv[%0d]: got %h want %h", r, obs_rv, exp_rv); end
      n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL odd_rv_count[%0d]: got %0d want %0d", r, got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g_len = got_q.pop_front(); e_len = exp_q.pop_front();
        n_vec++; if (g_len !== e_len) begin n_err++; $display("FAIL odd_len[%0d]: got %0d want %0d", r, g_len, e_len); end
      end
      n_vec++; if (bus.tok_total !== 16'(ref_total)) begin n_err++; $display("FAIL odd_total[%0d]: got %0d want %0d", r, bus.tok_total, ref_total); end
      n_vec++; if (bus.odd_err !== ref_odd) begin n_err++; $display("FAIL odd_flag[%0d]: got %b want %b", r, bus.odd_err, ref_odd); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    for (int r = 0; r < 3; r++) begin
      drive_run(2, 1); ref_apply(2, 1);
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL b2b_b[%0d]: got %h want %h", r, obs_b, exp_b); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL b2b_rv[%0d]: got %h want %h", r, obs_rv, exp_rv); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g_len = got_q.pop_front(); e_len = exp_q.pop_front();
        n_vec++; if (g_len !== e_len) begin n_err++; $display("FAIL b2b_len[%0d]: got %0d want %0d", r, g_len, e_len); end
      end
      n_vec++; if (got_q.size() + exp_q.size() != 0) begin n_err++; $display("FAIL b2b_rv_count[%0d]: got %0d extra want 0", r, got_q.size() + exp_q.size()); end
      got_q.delete(); exp_q.delete();
    end
    n_vec++; if (bus.tok_total !== 16'(ref_total)) begin n_err++; $display("FAIL b2b_total: got %0d want %0d", bus.tok_total, ref_total); end
    n_vec++; if (bus.odd_err !== ref_odd) begin n_err++; $display("FAIL b2b_odd: got %b want %b", bus.odd_err, ref_odd); end
  endtask

  task automatic test_boundary();
    int lens[4] = '{MAX_RUN, MAX_RUN + 1, 2, 5};
    do_reset(1'b0);
    foreach (lens[r]) begin
      drive_run(lens[r], 2); ref_apply(lens[r], 2);
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL bnd_b[%0d]: got %h want %h", r, obs_b, exp_b); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL bnd_rv[%0d]: got %h want %h", r, obs_rv, exp_rv); end
      n_vec++; if (obs_ovf !== exp_ovf) begin n_err++; $display("FAIL bnd_ovf_timing[%0d]: got %h want %h", r, obs_ovf, exp_ovf); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g_len = got_q.pop_front(); e_len = exp_q.pop_front();
        n_vec++; if (g_len !== e_len) begin n_err++; $display("FAIL bnd_len[%0d]: got %0d want %0d", r, g_len, e_len); end
      end
      n_vec++; if (got_q.size() + exp_q.size() != 0) begin n_err++; $display("FAIL bnd_rv_count[%0d]: got %0d extra want 0", r, got_q.size() + exp_q.size()); end
      got_q.delete(); exp_q.delete();
      n_vec++; if (bus.run_len !== LEN_W'(ref_len)) begin n_err++; $display("FAIL bnd_len_held[%0d]: got %0d want %0d", r, bus.run_len, ref_len); end
      n_vec++; if (bus.tok_total !== 16'(ref_total)) begin n_err++; $display("FAIL bnd_total[%0d]: got %0d want %0d", r, bus.tok_total, ref_total); end
      n_vec++; if (bus.overflow !== ref_ovf) begin n_err++; $display("FAIL bnd_ovf[%0d]: got %b want %b", r, bus.overflow, ref_ovf); end
      n_vec++; if (bus.odd_err !== ref_odd) begin n_err++; $display("FAIL bnd_odd[%0d]: got %b want %b", r, bus.odd_err, ref_odd); end
    end
  endtask

  task automatic test_sticky_reset();
    do_reset(1'b0);
    drive_run(3, 1); ref_apply(3, 1);
    drive_run(MAX_RUN + 1, 1); ref_apply(MAX_RUN + 1, 1);
    n_vec++; if ({bus.odd_err, bus.overflow} !== {ref_odd, ref_ovf}) begin
      n_err++; $display("FAIL sticky_set: got odd=%b ovf=%b want odd=%b ovf=%b", bus.odd_err, bus.overflow, ref_odd, ref_ovf);
    end
    drive_run(3, 0);
    rst = 1'b1; a = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.b, bus.run_valid, bus.run_len, bus.tok_total, bus.odd_err, bus.overflow} !== '0) begin
      n_err++; $display("FAIL sticky_reset_outputs: got b=%b rv=%b len=%0d tot=%0d odd=%b ovf=%b want all 0",
        bus.b, bus.run_valid, bus.run_len, bus.tok_total, bus.odd_err, bus.overflow);
    end
    rst = 1'b0; a = 1'b0;
    ref_reset();
    drive_run(2, 1); ref_apply(2, 1);
    n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL sticky_after_b: got %h want %h", obs_b, exp_b); end
    n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL sticky_after_rv: got %h want %h", obs_rv, exp_rv); end
    n_vec++; if (bus.run_len !== LEN_W'(ref_len)) begin n_err++; $display("FAIL sticky_after_len: got %0d want %0d", bus.run_len, ref_len); end
    n_vec++; if ({bus.odd_err, bus.overflow} !== 2'b00) begin n_err++; $display("FAIL sticky_after_flags: got %b%b want 00", bus.odd_err, bus.overflow); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    for (int r = 0; r < 20; r++) begin
      drive_run(2, 1); ref_apply(2, 1);
      n_vec++; if (obs_b4 !== exp_b) begin n_err++; $display("FAIL sat_b4[%0d]: got %h want %h", r, obs_b4, exp_b); end
      n_vec++; if (obs_rv4 !== exp_rv) begin n_err++; $display("FAIL sat_rv4[%0d]: got %h want %h", r, obs_rv4, exp_rv); end
      n_vec++; if (bus4.tok_total !== 4'(ref_total4)) begin n_err++; $display("FAIL sat_total4[%0d]: got %0d want %0d", r, bus4.tok_total, ref_total4); end
      got_q.delete(); exp_q.delete();
    end
    n_vec++; if (bus.tok_total !== 16'(ref_total)) begin n_err++; $display("FAIL sat_total16: got %0d want %0d", bus.tok_total, ref_total); end
  endtask

  task automatic test_random();
    int len, gap;
    do_reset(1'b0);
    for (int r = 0; r < 30; r++) begin
      len = $urandom_range(12, 1);
      gap = $urandom_range(3, 1);
      drive_run(len, gap); ref_apply(len, gap);
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL rnd_b[%0d] L=%0d: got %h want %h", r, len, obs_b, exp_b); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL rnd_rv[%0d] L=%0d: got %h want %h", r, len, obs_rv, exp_rv); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g_len = got_q.pop_front(); e_len = exp_q.pop_front();
        n_vec++; if (g_len !== e_len) begin n_err++; $display("FAIL rnd_len[%0d]: got %0d want %0d", r, g_len, e_len); end
      end
      got_q.delete(); exp_q.delete();
      n_vec++; if (bus.tok_total !== 16'(ref_total)) begin n_err++; $display("FAIL rnd_total[%0d]: got %0d want %0d", r, bus.tok_total, ref_total); end
      n_vec++; if (bus4.tok_total !== 4'(ref_total4)) begin n_err++; $display("FAIL rnd_total4[%0d]: got %0d want %0d", r, bus4.tok_total, ref_total4); end
      n_vec++; if (bus.odd_err !== ref_odd) begin n_err++; $display("FAIL rnd_odd[%0d]: got %b want %b", r, bus.odd_err, ref_odd); end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a   = 1'b0;
    ref_reset();
    test_reset();
    test_pair_decode();
    test_odd_run();
    test_back_to_back();
    test_boundary();
    test_sticky_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
